ahb_job_dispatch: RTL and testbench
===================================

# ahb_job_dispatch

AHB-Lite slave that hands out pixel jobs to the MIMD cores and tracks a batch from start to finish. Cores claim job indices by reading one register and report completion by writing another. The block also generates the one-cycle start/finish pulses and the completion count that drive the timer and digit display peripheral. It sits on the shared AHB-Lite bus beside the display peripheral, and its outputs are wired directly into that peripheral.

## Interface
- `W`, default 8: width of the batch-size, issue and completion counters.
- `HCLK` input 1: system clock.
- `HRESETn` input 1: asynchronous, active-low reset.
- `HADDR` input 32: only `HADDR[3:2]` is decoded.
- `HWDATA` input 32: write data.
- `HSIZE` input 3: word transfers only; ignored.
- `HTRANS` input 2: transfer type; `2'b00` is no transfer.
- `HWRITE` input 1: 1 = write.
- `HREADY` input 1: bus ready.
- `HSEL` input 1: slave select.
- `HRDATA` output 32: read data, valid in the data phase.
- `HREADYOUT` output 1: tied to 1; zero wait states.
- `done_count` output W: completions in the current batch.
- `timer_start` output 1: one-cycle pulse when a batch starts.
- `timer_finish` output 1: one-cycle pulse when a batch ends or is aborted.
- `busy` output 1: high while the FSM is in RUN.

## Operation
- **Address phase.** The block latches `write_enable` (= `HWRITE`), `read_enable` (= `!HWRITE`) and `word_address` (= `HADDR[3:2]`) when `HREADY && HSEL && HTRANS != 0`. Otherwise these latches clear to 0.
- **Word 0, CTRL.**
  - Write bit0 = start. It is honoured in IDLE or DONE only, and only if `batch_size != 0`.
  - Write bit1 = abort. It is honoured in any state.
  - If bit0 and bit1 are both set, abort wins.
  - Read returns `{30'b0, state==DONE, state==RUN}`.
- **Word 1, JOB.**
  - Read in RUN with `issued < batch_size` returns `{1'b1, 23'b0, issued}`. At the end of that data phase, `issued` increments by 1.
  - Any other read returns `32'h0` and has no side effect.
  - Writes are ignored.
- **Word 2, DONE.**
  - Write with any data, in RUN with `done_count < issued`, increments `done_count`. Otherwise the write is ignored, so the count never exceeds `issued`.
  - Read returns `done_count`, zero-extended.
- **Word 3, SIZE.**
  - Write in IDLE or DONE loads `batch_size <= HWDATA[W-1:0]`. Writes in RUN are ignored.
  - Read returns `{issued, batch_size}`, zero-extended, with `issued` in bits `[2W-1:W]`.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on an honoured start. Clear `issued` and `done_count`, and pulse `timer_start`.
  - DONE → RUN on an honoured start, with the same clears and pulse.
  - RUN → DONE on the DONE write that makes `done_count == batch_size`. Pulse `timer_finish`.
  - Any state → IDLE on abort. Clear `issued` and `done_count`. Pulse `timer_finish` only if the abort happens from RUN.
  - Illegal state encodings go to IDLE.
- **DONE state.** `done_count` holds its final value for display until the next start or abort.

## Timing
- **Reset values.** All of the following reset to 0: `HRDATA`, `done_count`, `timer_start`, `timer_finish`, `busy`, `issued`, `batch_size`, the address-phase latches. State resets to IDLE.
  - A reset during RUN returns the block to IDLE with no `timer_finish` pulse.
- **Register writes.** A write accepted in address phase cycle N updates registers, state and counters at the rising edge that ends the data phase (cycle N+1).
  - `busy` and `done_count` reflect the change in cycle N+2.
  - `timer_start` and `timer_finish` are registered. Each is high for exactly cycle N+2.
- **Reads.** `HRDATA` is combinational from the latched `word_address` and the current registers during the data phase.
  - For back-to-back JOB reads, each read sees the `issued` value left by the previous read, so no index is handed out twice.
- **Counter widths.** Counters are W bits and never wrap, because `issued <= batch_size <= 2^W-1`.
- **Pipelined accesses.** A DONE write followed immediately by a CTRL write is handled in order, one data phase each.

## Test plan
- **Basic batch:** reset; SIZE=3; CTRL=1 → `timer_start` high for 1 cycle and `busy=1`. Three JOB reads return `0x80000000`, `0x80000001`, `0x80000002`; a fourth read returns `0x0`.
- **Completion:** after the basic batch, three DONE writes → `done_count` steps 1, 2, 3. The third write produces a `timer_finish` pulse, `busy=0` and CTRL reads `0x2`. `done_count` holds at 3.
- **Over-report:** SIZE=4, start, one JOB read, then two DONE writes → `done_count=1` and the state stays RUN.
- **Abort:**
  - Mid-RUN, CTRL=3 → IDLE, `timer_finish` pulse, `done_count=0`.
  - CTRL=2 in IDLE → no pulse.
- **Config rules:** SIZE=0 then CTRL=1 → stays IDLE with no pulse. A SIZE write during RUN leaves `batch_size` unchanged.
- **Async reset:** assert `HRESETn=0` mid-batch, between clock edges → every output is 0 immediately and state is IDLE. No pulse follows reset release.

Source files
------------

// File: rtl/ahb_job_dispatch.sv
// ahb_job_dispatch: AHB-Lite slave handing out pixel job indices to cores and
// tracking batch completion; drives the timer/digit display peripheral.
//
// Ports:
//   HCLK, HRESETn       - clock, asynchronous active-low reset
//   HADDR[3:2]          - word select: 0 CTRL, 1 JOB, 2 DONE, 3 SIZE
//   HWDATA              - write data (data phase)
//   HSIZE               - ignored (word transfers only)
//   HTRANS/HWRITE/HREADY/HSEL - standard AHB-Lite address-phase controls
//   HRDATA              - read data, combinational in the data phase
//   HREADYOUT           - always 1 (zero wait states)
//   done_count          - completions reported in the current batch
//   timer_start         - one-cycle pulse when a batch starts
//   timer_finish        - one-cycle pulse when a batch completes or is aborted from RUN
//   busy                - high while a batch is running
`timescale 1ns/1ps
module ahb_job_dispatch #(
    parameter int unsigned W = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [31:0]   HADDR,
    input  logic [31:0]   HWDATA,
    input  logic [2:0]    HSIZE,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic          HREADY,
    input  logic          HSEL,
    output logic [31:0]   HRDATA,
    output logic          HREADYOUT,
    output logic [W-1:0]  done_count,
    output logic          timer_start,
    output logic          timer_finish,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic         r_we, r_re;
    logic [1:0]   r_addr;
    logic [W-1:0] r_issued, w_issued_nxt;
    logic [W-1:0] r_done, w_done_nxt;
    logic [W-1:0] r_batch, w_batch_nxt;
    logic         r_start, w_start_nxt;
    logic         r_finish, w_finish_nxt;

    logic         w_sel;
    logic         w_is_run;
    logic         w_can_start;
    logic         w_job_avail;
    logic         w_unused;

    assign w_sel       = HREADY && HSEL && (HTRANS != 2'b00);
    assign w_is_run    = (r_state == S_RUN);
    assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_job_avail = w_is_run && (r_issued < r_batch);
    assign w_unused    = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:W]};

    assign HREADYOUT    = 1'b1;
    assign done_count   = r_done;
    assign timer_start  = r_start;
    assign timer_finish = r_finish;
    assign busy         = w_is_run;

    // Address-phase capture; the data-phase work below uses these latches.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_addr <= 2'b00;
        end else if (w_sel) begin
            r_we   <= HWRITE;
            r_re   <= !HWRITE;
            r_addr <= HADDR[3:2];
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_addr <= 2'b00;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_issued <= '0;
            r_done   <= '0;
            r_batch  <= '0;
            r_start  <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_issued <= w_issued_nxt;
            r_done   <= w_done_nxt;
            r_batch  <= w_batch_nxt;
            r_start  <= w_start_nxt;
            r_finish <= w_finish_nxt;
        end
    end

    always_comb begin
        w_issued_nxt = r_issued;
        w_done_nxt   = r_done;
        w_batch_nxt  = r_batch;
        w_start_nxt  = 1'b0;
        w_finish_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_RUN, S_DONE: w_state_nxt = r_state;
            default:               w_state_nxt = S_IDLE;
        endcase

        if (r_we) begin
            case (r_addr)
                2'd0: begin
                    // Abort takes priority over a simultaneous start.
                    if (HWDATA[1]) begin
                        w_state_nxt  = S_IDLE;
                        w_issued_nxt = '0;
                        w_done_nxt   = '0;
                        w_finish_nxt = w_is_run;
                    end else if (HWDATA[0] && w_can_start && (r_batch != '0)) begin
                        w_state_nxt  = S_RUN;
                        w_issued_nxt = '0;
                        w_done_nxt   = '0;
                        w_start_nxt  = 1'b1;
                    end
                end
                2'd2: begin
                    // Only count completions for jobs actually handed out.
                    if (w_is_run && (r_done < r_issued)) begin
                        w_done_nxt = r_done + W'(1);
                        if (w_done_nxt == r_batch) begin
                            w_state_nxt  = S_DONE;
                            w_finish_nxt = 1'b1;
                        end
                    end
                end
                2'd3: begin
                    if (w_can_start) begin
                        w_batch_nxt = HWDATA[W-1:0];
                    end
                end
                default: ;
            endcase
        end else if (r_re && (r_addr == 2'd1) && w_job_avail) begin
            w_issued_nxt = r_issued + W'(1);
        end
    end

    always_comb begin
        HRDATA = '0;
        if (r_re) begin
            case (r_addr)
                2'd0:    HRDATA = {30'b0, r_state == S_DONE, r_state == S_RUN};
                2'd1:    if (w_job_avail) HRDATA = 32'h8000_0000 | 32'(r_issued);
                2'd2:    HRDATA = 32'(r_done);
                default: HRDATA = 32'({r_issued, r_batch});
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_job_dispatch.sv
// Bench for ahb_job_dispatch: directed bus traffic, a batch-level model
// checked every cycle, plus literal expectations at key points.
`timescale 1ns/1ps
module tb_ahb_job_dispatch;

    localparam int W = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [31:0]   HADDR = '0;
    logic [31:0]   HWDATA = '0;
    logic [2:0]    HSIZE = 3'd2;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic          HREADY = 1'b1;
    logic          HSEL = 1'b0;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic [W-1:0]  done_count;
    logic          timer_start;
    logic          timer_finish;
    logic          busy;

    ahb_job_dispatch #(.W(W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
        .HSEL(HSEL), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .done_count(done_count), .timer_start(timer_start),
        .timer_finish(timer_finish), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Batch-level model: a running flag, a finished flag and three counters.
    bit m_run, m_fin;
    int m_batch, m_issued, m_done;
    bit exp_start, exp_finish;
    bit p_valid, p_write;
    int p_word;

    function automatic logic [31:0] model_read(input int word);
        case (word)
            0: return {30'b0, m_fin, m_run};
            1: return (m_run && m_issued < m_batch) ? (32'h8000_0000 + m_issued) : 32'h0;
            2: return m_done;
            default: return (m_issued << W) + m_batch;
        endcase
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_run = 0; m_fin = 0; m_batch = 0; m_issued = 0; m_done = 0;
            exp_start = 0; exp_finish = 0; p_valid = 0; p_write = 0; p_word = 0;
        end else begin
            exp_start = 0;
            exp_finish = 0;
            if (p_valid) begin
                if (p_write && p_word == 0) begin
                    if (HWDATA[1]) begin
                        if (m_run) exp_finish = 1;
                        m_run = 0; m_fin = 0; m_issued = 0; m_done = 0;
                    end else if (HWDATA[0] && !m_run && m_batch != 0) begin
                        m_run = 1; m_fin = 0; m_issued = 0; m_done = 0;
                        exp_start = 1;
                    end
                end else if (!p_write && p_word == 1) begin
                    if (m_run && m_issued < m_batch) m_issued++;
                end else if (p_write && p_word == 2) begin
                    if (m_run && m_done < m_issued) begin
                        m_done++;
                        if (m_done == m_batch) begin
                            m_run = 0; m_fin = 1; exp_finish = 1;
                        end
                    end
                end else if (p_write && p_word == 3) begin
                    if (!m_run) m_batch = HWDATA & ((1 << W) - 1);
                end
            end
            p_valid = HSEL && HREADY && (HTRANS != 2'b00);
            p_write = HWRITE;
            p_word  = int'(HADDR[3:2]);
        end
    end

    always @(negedge HCLK) begin
        check("busy", {31'b0, busy}, {31'b0, m_run});
        check("done_count", 32'(done_count), m_done);
        check("timer_start", {31'b0, timer_start}, {31'b0, exp_start});
        check("timer_finish", {31'b0, timer_finish}, {31'b0, exp_finish});
        check("hreadyout", {31'b0, HREADYOUT}, 32'h1);
        if (p_valid && !p_write) check("hrdata", HRDATA, model_read(p_word));
    end

    task automatic addr_phase(input bit wr, input logic [1:0] w);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = {28'h0, w, 2'b00};
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] w, input logic [31:0] d);
        @(posedge HCLK); #1; addr_phase(1'b1, w);
        @(posedge HCLK); #1; bus_idle(); HWDATA = d;
    endtask

    task automatic bus_read(input logic [1:0] w, output logic [31:0] d);
        @(posedge HCLK); #1; addr_phase(1'b0, w);
        @(posedge HCLK); #1; bus_idle(); d = HRDATA;
    endtask

    task automatic bus_read2(input logic [1:0] w, output logic [31:0] d0, output logic [31:0] d1);
        @(posedge HCLK); #1; addr_phase(1'b0, w);
        @(posedge HCLK); #1; addr_phase(1'b0, w); d0 = HRDATA;
        @(posedge HCLK); #1; bus_idle(); d1 = HRDATA;
    endtask

    task automatic bus_write2(input logic [1:0] w0, input logic [31:0] d0,
                              input logic [1:0] w1, input logic [31:0] d1);
        @(posedge HCLK); #1; addr_phase(1'b1, w0);
        @(posedge HCLK); #1; addr_phase(1'b1, w1); HWDATA = d0;
        @(posedge HCLK); #1; bus_idle(); HWDATA = d1;
    endtask

    task automatic next_cycle();
        @(posedge HCLK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, d0, d1;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_done", 32'(done_count), 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        HRESETn = 1'b1;

        // Basic batch
        bus_write(2'd3, 32'd3);
        bus_write(2'd0, 32'h1);
        next_cycle();
        check("start_pulse", {31'b0, timer_start}, 32'h1);
        check("start_busy", {31'b0, busy}, 32'h1);
        next_cycle();
        check("start_pulse_end", {31'b0, timer_start}, 32'h0);
        bus_read2(2'd1, d0, d1);
        check("job0", d0, 32'h8000_0000);
        check("job1", d1, 32'h8000_0001);
        bus_read(2'd1, d);
        check("job2", d, 32'h8000_0002);
        bus_read(2'd1, d);
        check("job_exhausted", d, 32'h0);

        // Completion
        for (int i = 1; i <= 3; i++) begin
            bus_write(2'd2, 32'hdead_beef);
            next_cycle();
            check("done_step", 32'(done_count), i);
        end
        check("finish_pulse", {31'b0, timer_finish}, 32'h1);
        check("finish_busy", {31'b0, busy}, 32'h0);
        bus_read(2'd0, d);
        check("ctrl_done", d, 32'h2);
        check("done_hold", 32'(done_count), 32'd3);

        // Over-report
        bus_write(2'd3, 32'd4);
        bus_write(2'd0, 32'h1);
        bus_read(2'd1, d);
        check("over_job0", d, 32'h8000_0000);
        bus_write(2'd2, 32'h0);
        bus_write(2'd2, 32'h0);
        next_cycle();
        check("over_done", 32'(done_count), 32'd1);
        bus_read(2'd0, d);
        check("over_ctrl_run", d, 32'h1);

        // Abort from RUN with both bits set
        bus_write(2'd0, 32'h3);
        next_cycle();
        check("abort_finish", {31'b0, timer_finish}, 32'h1);
        check("abort_done", 32'(done_count), 32'h0);
        bus_read(2'd0, d);
        check("abort_ctrl", d, 32'h0);
        bus_write(2'd0, 32'h2);
        next_cycle();
        check("idle_abort_nopulse", {31'b0, timer_finish}, 32'h0);

        // Config rules
        bus_write(2'd3, 32'd0);
        bus_write(2'd0, 32'h1);
        next_cycle();
        check("size0_nostart", {31'b0, timer_start}, 32'h0);
        check("size0_idle", {31'b0, busy}, 32'h0);
        bus_write(2'd3, 32'd2);
        bus_write(2'd0, 32'h1);
        bus_write(2'd3, 32'd5);
        bus_read(2'd3, d);
        check("size_locked", d, 32'h0000_0002);
        bus_read(2'd1, d);
        check("job_b0", d, 32'h8000_0000);
        bus_read(2'd3, d);
        check("size_issued", d, 32'h0000_0102);
        bus_read(2'd1, d);
        check("job_b1", d, 32'h8000_0001);

        // DONE write pipelined with an abort
        bus_write(2'd2, 32'h0);
        bus_write2(2'd2, 32'h0, 2'd0, 32'h2);
        check("pipe_finish", {31'b0, timer_finish}, 32'h1);
        check("pipe_done_final", 32'(done_count), 32'd2);
        next_cycle();
        check("pipe_abort_nopulse", {31'b0, timer_finish}, 32'h0);
        check("pipe_abort_clear", 32'(done_count), 32'h0);

        // Async reset mid-batch
        bus_write(2'd3, 32'd3);
        bus_write(2'd0, 32'h1);
        bus_read(2'd1, d);
        bus_write(2'd2, 32'h0);
        @(posedge HCLK);
        #1; addr_phase(1'b0, 2'd2);
        @(posedge HCLK);
        #3;
        check("pre_rst_hrdata", HRDATA, 32'h1);
        HRESETn = 1'b0;
        #1;
        check("arst_hrdata", HRDATA, 32'h0);
        check("arst_done", 32'(done_count), 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        check("arst_start", {31'b0, timer_start}, 32'h0);
        check("arst_finish", {31'b0, timer_finish}, 32'h0);
        bus_idle();
        @(posedge HCLK); #2;
        HRESETn = 1'b1;
        repeat (4) next_cycle();
        bus_read(2'd0, d);
        check("post_rst_ctrl", d, 32'h0);
        bus_read(2'd3, d);
        check("post_rst_size", d, 32'h0);
        repeat (2) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
